// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode seven-segment driver with a load-strobed shadow word
// committed only at frame boundaries, hex decode and optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PS_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        pending
);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     active_q, active_d;
  logic            pending_q, pending_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            frame_done_q;
  logic            tick, frame;
  logic [3:0]      nib;
  logic            lz;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick      = (ps_q == PS_W'(PRESCALE - 1));
    ps_d      = tick ? '0 : ps_q + PS_W'(1);
    idx_d     = tick ? idx_q - 2'd1 : idx_q;
    frame     = tick && (idx_q == 2'd0);
    active_d  = (frame && pending_q) ? shadow_q : active_q;
    shadow_d  = load ? din : shadow_q;
    // A load on the boundary edge wins over the clear: the new word waits a frame.
    pending_d = load ? 1'b1 : (frame ? 1'b0 : pending_q);

    // Decode from the post-commit word so digit 3 of a new frame shows it immediately.
    case (idx_d)
      2'd3: begin
        nib = active_d[15:12];
        lz  = (active_d[15:12] == 4'h0);
      end
      2'd2: begin
        nib = active_d[11:8];
        lz  = (active_d[15:8] == 8'h00);
      end
      2'd1: begin
        nib = active_d[7:4];
        lz  = (active_d[15:4] == 12'h000);
      end
      default: begin
        nib = active_d[3:0];
        lz  = 1'b0;
      end
    endcase

    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      if (blank_lz && lz) begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
      end else begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = hex2seg(nib);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q         <= '0;
      idx_q        <= 2'd3;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      an_q         <= 4'b0111;
      seg_q        <= 7'h40;
      frame_done_q <= 1'b0;
    end else begin
      ps_q         <= ps_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver against a cycle-count based reference
// model of the display (digit = slot number, commit at every 4*PRESCALE edges).
module tb_seg7_scan_driver;

  localparam int unsigned P     = 4;
  localparam int unsigned FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  seg7_scan_driver #(
    .PRESCALE(P),
    .PS_W    (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .load      (load),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: m_n counts edges since the last reset edge.
  int          m_n;
  logic [15:0] m_shadow, m_active;
  logic        m_pending;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_fd;
  logic        bl_cur = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cycle(input logic r, input logic ld, input logic [15:0] d, input logic bl);
    int k;
    logic [15:0] upper;
    rst = r; load = ld; din = d; blank_lz = bl;
    @(posedge clk);
    if (r) begin
      m_n = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0;
      exp_an = 4'b0111; exp_seg = 7'h40; exp_fd = 1'b0;
    end else begin
      m_n++;
      exp_fd = (m_n % FRAME == 0);
      if (exp_fd && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      if (ld) begin
        m_shadow  = d;
        m_pending = 1'b1;
      end
      if (m_n % P == 0) begin
        k     = 3 - ((m_n / P) % 4);
        upper = m_active >> (4 * k);
        if (bl && k != 0 && upper == 16'h0) begin
          exp_an = 4'b1111; exp_seg = 7'h7F;
        end else begin
          exp_an = 4'b1111 & ~(4'b0001 << k);
          exp_seg = glyph[upper[3:0]];
        end
      end
    end
    #1;
  endtask

  task automatic advance_to(input int phase);
    for (int i = 0; i < FRAME && (m_n % FRAME) != phase; i++) cycle(1'b0, 1'b0, 16'h0, bl_cur);
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    n_checks++; if (an !== 4'b0111) begin n_fail++; $display("FAIL reset_an got %b exp 0111", an); end
    n_checks++; if (seg !== 7'h40) begin n_fail++; $display("FAIL reset_seg got %h exp 40", seg); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", pending); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b exp 0", frame_done); end
  endtask

  task automatic test_scan;
    int pulses = 0;
    int where  = -1;
    for (int i = 0; i < 16; i++) begin
      // After reset edge plus i edges, slot i/4 should be lit.
      n_checks++;
      if (an !== (4'b1111 & ~(4'b1000 >> (i / 4)))) begin
        n_fail++; $display("FAIL scan_an cyc %0d got %b", i, an);
      end
      n_checks++; if (seg !== 7'h40) begin n_fail++; $display("FAIL scan_seg cyc %0d got %h exp 40", i, seg); end
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      if (frame_done === 1'b1) begin pulses++; where = i + 1; end
    end
    n_checks++; if (pulses != 1 || where != 16) begin
      n_fail++; $display("FAIL scan_fd pulses %0d at edge %0d exp 1 at 16", pulses, where);
    end
  endtask

  task automatic test_capture;
    int bad_seen = 0;
    advance_to(6);
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL cap_pending got %b exp 1", pending); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL cap_an n %0d got %b exp %b", m_n, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL cap_seg n %0d got %h exp %h", m_n, seg, exp_seg); end
      n_checks++; if (pending !== m_pending) begin n_fail++; $display("FAIL cap_pend n %0d got %b exp %b", m_n, pending, m_pending); end
    end
    // Last-wins overwrite: ABCD must never reach the display.
    advance_to(2);
    cycle(1'b0, 1'b1, 16'hABCD, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'hEF01, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      if (seg === 7'h08 || seg === 7'h03 || seg === 7'h46 || seg === 7'h21) bad_seen++;
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL ovw_an n %0d got %b exp %b", m_n, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL ovw_seg n %0d got %h exp %h", m_n, seg, exp_seg); end
    end
    n_checks++; if (bad_seen != 0) begin n_fail++; $display("FAIL ovw_abcd seen %0d times exp 0", bad_seen); end
  endtask

  task automatic test_boundary_load;
    advance_to(3);
    cycle(1'b0, 1'b1, 16'h5678, 1'b0);
    advance_to(FRAME - 1);
    cycle(1'b0, 1'b1, 16'h00F0, 1'b0);
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL bnd_fd got %b exp 1", frame_done); end
    n_checks++; if (seg !== 7'h12) begin n_fail++; $display("FAIL bnd_first got %h exp 12", seg); end
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL bnd_pend got %b exp 1", pending); end
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL bnd_an n %0d got %b exp %b", m_n, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL bnd_seg n %0d got %h exp %h", m_n, seg, exp_seg); end
      n_checks++; if (pending !== m_pending) begin n_fail++; $display("FAIL bnd_pend n %0d got %b exp %b", m_n, pending, m_pending); end
      n_checks++; if (frame_done !== exp_fd) begin n_fail++; $display("FAIL bnd_fdc n %0d got %b exp %b", m_n, frame_done, exp_fd); end
    end
  endtask

  task automatic test_blanking;
    logic [15:0] words [3] = '{16'h0007, 16'h0000, 16'h0300};
    bl_cur = 1'b1;
    for (int w = 0; w < 3; w++) begin
      advance_to(1);
      cycle(1'b0, 1'b1, words[w], 1'b1);
      advance_to(0);
      for (int i = 0; i < FRAME; i++) begin
        n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL blk_an w %h n %0d got %b exp %b", words[w], m_n, an, exp_an); end
        n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL blk_seg w %h n %0d got %h exp %h", words[w], m_n, seg, exp_seg); end
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
      end
    end
    // Spot check against literal values: 0300 frame's digit 3 slot is blanked.
    advance_to(1);
    n_checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL blk_lit got an %b seg %h exp 1111 7f", an, seg);
    end
    bl_cur = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int nine_seen = 0;
    advance_to(3);
    cycle(1'b0, 1'b1, 16'h9999, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    n_checks++; if (an !== 4'b0111) begin n_fail++; $display("FAIL rmf_an got %b exp 0111", an); end
    n_checks++; if (seg !== 7'h40) begin n_fail++; $display("FAIL rmf_seg got %h exp 40", seg); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL rmf_pend got %b exp 0", pending); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      if (seg === 7'h10) nine_seen++;
    end
    n_checks++; if (nine_seen != 0) begin n_fail++; $display("FAIL rmf_word seen %0d exp 0", nine_seen); end
  endtask

  task automatic test_random;
    logic r, ld, bl;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 9) == 0);
      bl = ($urandom_range(0, 3) != 0);
      cycle(r, ld, 16'($urandom), bl);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL rnd_an n %0d got %b exp %b", m_n, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL rnd_seg n %0d got %h exp %h", m_n, seg, exp_seg); end
      n_checks++; if (pending !== m_pending) begin n_fail++; $display("FAIL rnd_pend n %0d got %b exp %b", m_n, pending, m_pending); end
      n_checks++; if (frame_done !== exp_fd) begin n_fail++; $display("FAIL rnd_fd n %0d got %b exp %b", m_n, frame_done, exp_fd); end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_capture;
    test_boundary_load;
    test_blanking;
    test_reset_midframe;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Receive end of the 16-bit four-nibble display word produced by the scrolling counters; drives a physical 4-digit multiplexed common-anode seven-segment display.
- Captures the word through a load strobe and holds it in a shadow register.
- Commits the shadow word only at frame boundaries, so there is no tearing.
- Time-multiplexes the digits with a prescaler, decodes hex to segments and optionally blanks leading zeros.

Parameters:
- PRESCALE, 50000, clk cycles each digit is lit (minimum 2).
- PS_W, 16, prescaler counter width; must satisfy 2^PS_W >= PRESCALE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  16  display word; din[15:12] is the leftmost digit (digit 3), din[3:0] is the rightmost (digit 0).
- load  input  1  one-cycle capture strobe for din.
- blank_lz  input  1  1 = blank leading zero digits.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit enables, an[3] = leftmost, active-low, registered.
- frame_done  output  1  one-cycle pulse at each frame boundary.
- pending  output  1  shadow word waiting to be committed.

Behaviour:
- Reset (rst high at a rising edge) sets:
  - shadow = 0, active = 0, pending = 0;
  - prescaler = 0, digit index = 3;
  - an = 4'b0111, seg = 7'h40 (glyph "0"), frame_done = 0.
- Reset mid-frame discards any pending word.
- Capture:
  - load=1 at an edge copies din into shadow and sets pending=1 on that edge.
  - A later load while pending=1 overwrites shadow; the last one wins.
  - load is ignored while rst=1.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - The terminal count (PRESCALE-1) is the "tick".
- Digit sequencing:
  - On each tick edge the index steps 3->2->1->0->3.
  - an and seg for the new index are valid on the same edge; outputs are registered, so there is no combinational path from din.
- Frame boundary, defined as the tick edge where the index goes 0->3:
  - frame_done=1 for exactly that one cycle.
  - If pending=1 (sampled before the edge), active <= shadow and pending <= 0, and digit 3 of the new frame already shows the new word.
  - If load and a frame boundary fall on the same edge, the old shadow (if pending) is committed. The new din goes into shadow with pending=1, which is shown next frame.
  - If pending=0 at the boundary, active is unchanged.
- Decode, hex to seg (active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
- Leading-zero blanking, when blank_lz=1 (the active register is the source):
  - Digit k (k=3,2,1) is blanked iff active nibble k and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - A blanked digit has an = 4'b1111 and seg = 7'h7F for its whole slot.
  - blank_lz is sampled when the slot's outputs are registered.
- Exactly one an bit is low at any time, except during blanked slots.

Test Plan (PRESCALE=4):
1. Reset, then run 16 cycles -> an sequence 0111, 1011, 1101, 1110, 4 cycles each, seg=40 each; frame_done pulses once, on the edge where the index goes 0->3.
2. load with din=16'h1234 mid-frame -> pending=1 until the next boundary, then 0. The next frame shows seg 79, 24, 30, 19 on digits 3..0; the current frame still shows 0s.
3. load 16'hABCD, then load 16'hEF01 two cycles later, both before the boundary -> only E, F, 0, 1 are shown (06, 0E, 40, 79); ABCD never appears.
4. load 16'h00F0 on the exact boundary edge while pending holds 16'h5678 -> the following frame shows 5678, the frame after shows 00F0, and pending clears after the second commit.
5. blank_lz=1 with active 16'h0007 -> digits 3..1 show an=1111, seg=7F; digit 0 shows an=1110, seg=78. With 16'h0000, only digit 0 is lit, showing "0". With 16'h0300, digit 3 is blanked and digits 2..0 show 3, 0, 0.
6. Assert rst mid-frame with pending=1 -> on the next edge an=0111, seg=40, pending=0; the pending word never appears.
